rw_write_arbiter: RTL and testbench

- Shares the single RW data-array write port (waddr/wdata/wstrb/wid, bvalid/bid) among N write_rw-style requesters in a tile.
- Round-robin arbitration; registered output stage.
- Tags the outbound write id with the requester index and routes each write response back to its requester.
- Caps outstanding writes per requester so one unit cannot monopolise the response path.

---
 rtl/rw_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_rw_write_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rw_write_arbiter.sv
// Round-robin arbiter sharing one RW data-array write port among N requesters,
// with registered output stage, id tagging, response routing and per-requester
// outstanding caps. Optional perf counters behind RW_WRITE_ARB_PERF_EN.
module rw_write_arbiter #(
    parameter int N       = 4,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4,
    parameter int LOG_N   = (N > 2) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N-1:0]            s_wvalid,
    output logic [N-1:0]            s_wready,
    input  logic [N*32-1:0]         s_waddr,
    input  logic [N*512-1:0]        s_wdata,
    input  logic [N*64-1:0]         s_wstrb,
    input  logic [N*ID_W-1:0]       s_wid,
    output logic [N-1:0]            s_bvalid,
    input  logic [N-1:0]            s_bready,
    output logic [ID_W-1:0]         s_bid,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [31:0]             m_waddr,
    output logic [511:0]            m_wdata,
    output logic [63:0]             m_wstrb,
    output logic [LOG_N+ID_W-1:0]   m_wid,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [LOG_N+ID_W-1:0]   m_bid,
    output logic                    err_bad_bid
`ifdef RW_WRITE_ARB_PERF_EN
    ,
    output logic [(2*N+1)*32-1:0]   perf_flat
`endif
);

    // Handshakes: a write transfers on s_wvalid[i] & s_wready[i] and on
    // m_wvalid & m_wready; a response transfers on m_bvalid & m_bready.
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int WID_W = LOG_N + ID_W;

    logic [LOG_N-1:0] rr_ptr;
    logic [CNT_W-1:0] out_cnt [N];
    logic [N-1:0]     eligible;
    logic             load;
    logic             gnt_valid;
    logic [LOG_N-1:0] gnt_idx;
    int               scan_idx;

    logic [LOG_N-1:0] bid_idx;
    logic             bid_ok;
    logic             resp_fire;
    logic [N-1:0]     resp_hit;
    logic             cnt_zero_hit;
    logic             bad_resp;

    assign load = !m_wvalid || m_wready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eligible[i] = s_wvalid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    // First eligible requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N;
            if (!gnt_valid && eligible[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = LOG_N'(scan_idx);
            end
        end
        if (!rstn || !load) begin
            gnt_valid = 1'b0;
            gnt_idx   = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_wready[i] = gnt_valid && (gnt_idx == LOG_N'(i));
        end
    end

    assign bid_idx = m_bid[WID_W-1:ID_W];
    assign bid_ok  = (int'(bid_idx) < N);
    assign s_bid   = m_bid[ID_W-1:0];

    // Responses with an out-of-range index are drained so they cannot block.
    always_comb begin
        s_bvalid     = '0;
        m_bready     = 1'b0;
        resp_hit     = '0;
        cnt_zero_hit = 1'b0;
        resp_fire    = 1'b0;
        if (rstn) begin
            m_bready = !bid_ok;
            for (int i = 0; i < N; i++) begin
                if (bid_ok && (bid_idx == LOG_N'(i))) begin
                    s_bvalid[i] = m_bvalid;
                    m_bready    = s_bready[i];
                end
            end
        end
        resp_fire = m_bvalid && m_bready;
        for (int i = 0; i < N; i++) begin
            if (s_bvalid[i] && m_bready) begin
                resp_hit[i] = 1'b1;
                if (out_cnt[i] == '0) cnt_zero_hit = 1'b1;
            end
        end
    end

    assign bad_resp = resp_fire && (!bid_ok || cnt_zero_hit);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr      <= '0;
            m_wvalid    <= 1'b0;
            err_bad_bid <= 1'b0;
            for (int i = 0; i < N; i++) out_cnt[i] <= '0;
        end else begin
            if (gnt_valid) begin
                rr_ptr   <= (gnt_idx == LOG_N'(N - 1)) ? '0 : gnt_idx + 1'b1;
                m_wvalid <= 1'b1;
            end else if (load) begin
                m_wvalid <= 1'b0;
            end
            if (bad_resp) err_bad_bid <= 1'b1;
            // Saturating at zero covers responses to writes issued before reset.
            for (int i = 0; i < N; i++) begin
                if (s_wready[i] && !resp_hit[i]) begin
                    out_cnt[i] <= out_cnt[i] + 1'b1;
                end else if (!s_wready[i] && resp_hit[i] && (out_cnt[i] != '0)) begin
                    out_cnt[i] <= out_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_valid) begin
            m_waddr <= s_waddr[32*gnt_idx +: 32];
            m_wdata <= s_wdata[512*gnt_idx +: 512];
            m_wstrb <= s_wstrb[64*gnt_idx +: 64];
            m_wid   <= {gnt_idx, s_wid[ID_W*gnt_idx +: ID_W]};
        end
    end

`ifdef RW_WRITE_ARB_PERF_EN
    logic [31:0] perf_gnt   [N];
    logic [31:0] perf_stall [N];
    logic [31:0] perf_bp;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_bp <= '0;
            for (int i = 0; i < N; i++) begin
                perf_gnt[i]   <= '0;
                perf_stall[i] <= '0;
            end
        end else begin
            if (m_wvalid && !m_wready) perf_bp <= perf_bp + 32'd1;
            for (int i = 0; i < N; i++) begin
                if (s_wready[i]) perf_gnt[i] <= perf_gnt[i] + 32'd1;
                if (s_wvalid[i] && !s_wready[i]) perf_stall[i] <= perf_stall[i] + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_perf
        assign perf_flat[32*gi +: 32]     = perf_gnt[gi];
        assign perf_flat[32*(N+gi) +: 32] = perf_stall[gi];
    end
    assign perf_flat[32*(2*N) +: 32] = perf_bp;
`endif

endmodule

// File: tb/tb_rw_write_arbiter.sv
// Directed table-driven bench for rw_write_arbiter (N=4), plus a second N=5
// instance used to exercise out-of-range response indices.
module tb_rw_write_arbiter;

    logic           clk;
    logic           rstn;
    logic [3:0]     s_wvalid, s_wready, s_bvalid, s_bready;
    logic [127:0]   s_waddr;
    logic [2047:0]  s_wdata;
    logic [255:0]   s_wstrb;
    logic [15:0]    s_wid;
    logic [3:0]     s_bid;
    logic           m_wvalid, m_wready, m_bvalid, m_bready, err_bad_bid;
    logic [31:0]    m_waddr;
    logic [511:0]   m_wdata;
    logic [63:0]    m_wstrb;
    logic [5:0]     m_wid, m_bid;

    logic [4:0]     s_wready5, s_bvalid5;
    logic [3:0]     s_bid5;
    logic           m_wvalid5, m_bvalid5, m_bready5, err5;
    logic [31:0]    m_waddr5;
    logic [511:0]   m_wdata5;
    logic [63:0]    m_wstrb5;
    logic [6:0]     m_wid5, m_bid5;

    int n_vec = 0;
    int n_err = 0;

    rw_write_arbiter #(.N(4), .ID_W(4), .MAX_OUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_waddr(s_waddr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wid(s_wid),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
        .err_bad_bid(err_bad_bid)
    );

    rw_write_arbiter #(.N(5), .ID_W(4), .MAX_OUT(4)) dut5 (
        .clk(clk), .rstn(rstn),
        .s_wvalid(5'b0), .s_wready(s_wready5), .s_waddr(160'b0),
        .s_wdata(2560'b0), .s_wstrb(320'b0), .s_wid(20'b0),
        .s_bvalid(s_bvalid5), .s_bready(5'b0), .s_bid(s_bid5),
        .m_wvalid(m_wvalid5), .m_wready(1'b1), .m_waddr(m_waddr5),
        .m_wdata(m_wdata5), .m_wstrb(m_wstrb5), .m_wid(m_wid5),
        .m_bvalid(m_bvalid5), .m_bready(m_bready5), .m_bid(m_bid5),
        .err_bad_bid(err5)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic [3:0] wv;
        logic       mwr;
        logic       bv;
        logic [5:0] bid;
        logic [3:0] br;
        logic [3:0] e_wr;
        logic [3:0] e_bv;
        logic       e_mbr;
        logic       e_mwv;
        logic [1:0] e_g;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] wv, logic mwr, logic bv,
                                logic [5:0] bid, logic [3:0] br, logic [3:0] e_wr,
                                logic [3:0] e_bv, logic e_mbr, logic e_mwv,
                                logic [1:0] e_g, logic e_err);
        vec_t v;
        v.rst = rst; v.wv = wv; v.mwr = mwr; v.bv = bv; v.bid = bid; v.br = br;
        v.e_wr = e_wr; v.e_bv = e_bv; v.e_mbr = e_mbr; v.e_mwv = e_mwv;
        v.e_g = e_g; v.e_err = e_err;
        return v;
    endfunction

    // Scoreboard compare
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        rstn     = 1'b0;
        s_wvalid = 4'hF;
        m_wready = 1'b1;
        m_bvalid = 1'b1;
        m_bid    = 6'h00;
        s_bready = 4'hF;
        m_bvalid5 = 1'b0;
        m_bid5   = 7'h0;
        #2;
        chk("rst_s_wready", 64'(s_wready), 64'h0);
        chk("rst_s_bvalid", 64'(s_bvalid), 64'h0);
        chk("rst_m_bready", 64'(m_bready), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_m_wvalid", 64'(m_wvalid), 64'h0);
        chk("rst_err", 64'(err_bad_bid), 64'h0);
        chk("rst_err5", 64'(err5), 64'h0);
        rstn = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        logic [511:0] ewd;
        logic [5:0]   ewid;
        if (v.rst) do_reset();
        s_wvalid = v.wv;
        m_wready = v.mwr;
        m_bvalid = v.bv;
        m_bid    = v.bid;
        s_bready = v.br;
        #2;
        chk("s_wready", 64'(s_wready), 64'(v.e_wr));
        chk("s_bvalid", 64'(s_bvalid), 64'(v.e_bv));
        chk("m_bready", 64'(m_bready), 64'(v.e_mbr));
        if (v.bv) chk("s_bid", 64'(s_bid), 64'(v.bid[3:0]));
        @(posedge clk); #1;
        chk("m_wvalid", 64'(m_wvalid), 64'(v.e_mwv));
        chk("err_bad_bid", 64'(err_bad_bid), 64'(v.e_err));
        if (v.e_mwv) begin
            ewd  = {16{32'hA5A50000 + 32'(v.e_g)}};
            ewid = {v.e_g, 4'({2'b00, v.e_g} + 4'd2)};
            chk("m_waddr", 64'(m_waddr), 64'(32'h40 * 32'(v.e_g)));
            chk("m_wid", 64'(m_wid), 64'(ewid));
            chk("m_wdata_lo", m_wdata[63:0], ewd[63:0]);
            chk("m_wdata_hi", m_wdata[511:448], ewd[511:448]);
            chk("m_wstrb", m_wstrb, 64'hF << (4 * v.e_g));
        end
    endtask

    initial begin
        rstn = 1'b0;
        s_wvalid = '0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; s_bready = '0;
        m_bvalid5 = 1'b0; m_bid5 = '0;
        for (int i = 0; i < 4; i++) begin
            s_waddr[32*i +: 32]   = 32'h40 * 32'(i);
            s_wdata[512*i +: 512] = {16{32'hA5A50000 + 32'(i)}};
            s_wstrb[64*i +: 64]   = 64'hF << (4 * i);
            s_wid[4*i +: 4]       = 4'(i + 2);
        end

        // Single write from requester 1 (addr 0x40, id 3) and its response.
        vecs.push_back(mk(1, 4'b0010, 1, 0, 6'h00, 4'b0000, 4'b0010, 4'b0000, 0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 6'h13, 4'b0010, 4'b0000, 4'b0010, 1, 0, 2'd0, 0));
        // All requesters valid: grants rotate 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(k == 0, 4'hF, 1, 0, 6'h00, 4'b0000, 4'(1 << (k % 4)),
                              4'b0000, 0, 1, 2'(k % 4), 0));
        // Backpressure: outputs hold on requester 3, no grants, pointer frozen.
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 4'hF, 0, 0, 6'h00, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd3, 0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 6'h00, 4'b0000, 4'b0001, 4'b0000, 0, 1, 2'd0, 0));
        // Requester 2 reaches its outstanding cap, requester 0 still served.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(k == 0, 4'b0100, 1, 0, 6'h00, 4'b0000, 4'b0100, 4'b0000, 0, 1, 2'd2, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 6'h00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'b0101, 1, 0, 6'h00, 4'b0000, 4'b0001, 4'b0000, 0, 1, 2'd0, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 1, 6'h24, 4'b0000, 4'b0000, 4'b0100, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 1, 6'h24, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 6'h00, 4'b0000, 4'b0100, 4'b0000, 0, 1, 2'd2, 0));
        // Grant and response to requester 1 together at count 2: count stays 2,
        // so exactly two more grants fit before the cap.
        vecs.push_back(mk(1, 4'b0010, 1, 0, 6'h00, 4'b0000, 4'b0010, 4'b0000, 0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 6'h00, 4'b0000, 4'b0010, 4'b0000, 0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 1, 6'h13, 4'b0010, 4'b0010, 4'b0010, 1, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 6'h00, 4'b0000, 4'b0010, 4'b0000, 0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 6'h00, 4'b0000, 4'b0010, 4'b0000, 0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 6'h00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
        // Response to requester 0 with nothing outstanding: routed, flags error, sticky.
        vecs.push_back(mk(1, 4'b0000, 1, 1, 6'h02, 4'b0001, 4'b0000, 4'b0001, 1, 0, 2'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 6'h00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 6'h00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));

        for (int n = 0; n < vecs.size(); n++) apply(vecs[n]);

        // Out-of-range response index 5 on the N=5 instance: drained, not routed.
        m_bvalid5 = 1'b1;
        m_bid5    = {3'd5, 4'd1};
        #2;
        chk("bad_idx_m_bready", 64'(m_bready5), 64'h1);
        chk("bad_idx_s_bvalid", 64'(s_bvalid5), 64'h0);
        @(posedge clk); #1;
        chk("bad_idx_err", 64'(err5), 64'h1);
        m_bvalid5 = 1'b0;
        @(posedge clk); #1;
        chk("bad_idx_err_sticky", 64'(err5), 64'h1);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
